tb_axis_pulser: RTL

TB_AXIS_PULSER -- requirements
Module: tb_axis_pulser

---
 rtl/tb_axis_pulser.sv | 118 +++++++++++
 1 files changed

// File: rtl/tb_axis_pulser.sv
// Mouse-delta to stepper pulse converter: packets accumulate in per-axis quarter-step
// accumulators that drain one step (4 quarters) per prescaler tick as a toggled step clock.
`timescale 1ns/1ps
module tb_axis_pulser #(
   parameter int unsigned STEP_DIV = 1000,
   parameter int unsigned ACC_W    = 14
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        en,
   input  logic [24:0] ps2_mouse,
   input  logic [1:0]  mouse_speed,
   input  logic        flip,
   output logic        h_dir,
   output logic        h_clk,
   output logic        v_dir,
   output logic        v_clk
);

   localparam int unsigned PW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
   localparam int unsigned SW = ((ACC_W > 12) ? ACC_W : 12) + 2;
   localparam logic [PW-1:0] PRE_LAST = PW'(STEP_DIV - 1);
   localparam logic signed [SW-1:0] ACC_MAX = {{(SW-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
   localparam logic signed [SW-1:0] ACC_MIN = {{(SW-ACC_W+1){1'b1}}, {(ACC_W-1){1'b0}}};
   localparam logic signed [SW-1:0] QSTEP   = SW'(4);
   localparam logic signed [SW-1:0] QSTEP_N = -QSTEP;

   logic [PW-1:0]           pre_q, pre_d;
   logic                    tick;
   logic                    arm_q, tog_q;
   logic                    pkt_q, pkt_d;
   logic signed [11:0]      add_q [2];
   logic signed [11:0]      add_d [2];
   logic signed [ACC_W-1:0] acc_q [2];
   logic signed [ACC_W-1:0] acc_d [2];
   logic                    dir_q [2];
   logic                    dir_d [2];
   logic                    stp_q [2];
   logic                    stp_d [2];
   logic [8:0]              delta [2];
   logic                    want  [2];
   logic signed [SW-1:0]    acc_x [2];
   logic signed [SW-1:0]    add_x [2];
   logic signed [SW-1:0]    cons  [2];
   logic signed [SW-1:0]    sum   [2];
   logic                    unused_bits;

   assign unused_bits = ^{ps2_mouse[7:6], ps2_mouse[3:0]};

   always_comb begin
      tick     = (pre_q == PRE_LAST);
      pre_d    = tick ? '0 : pre_q + 1'b1;
      // Toggle tracking runs even while paused; only acceptance is gated by en.
      pkt_d    = en && arm_q && (ps2_mouse[24] != tog_q);
      delta[0] = {ps2_mouse[4], ps2_mouse[15:8]};
      delta[1] = {ps2_mouse[5], ps2_mouse[23:16]};
      for (int unsigned a = 0; a < 2; a++) begin
         add_d[a] = $signed({{3{delta[a][8]}}, delta[a]}) <<< mouse_speed;
         acc_x[a] = $signed({{(SW-ACC_W){acc_q[a][ACC_W-1]}}, acc_q[a]});
         add_x[a] = pkt_q ? $signed({{(SW-12){add_q[a][11]}}, add_q[a]}) : '0;
         want[a]  = ~acc_x[a][SW-1];
         cons[a]  = '0;
         dir_d[a] = dir_q[a];
         stp_d[a] = stp_q[a];
         // A direction change spends its tick on setup; only a settled direction steps.
         if (en && tick && ((acc_x[a] >= QSTEP) || (acc_x[a] <= QSTEP_N))) begin
            if (dir_q[a] == want[a]) begin
               stp_d[a] = ~stp_q[a];
               cons[a]  = want[a] ? QSTEP : QSTEP_N;
            end else begin
               dir_d[a] = want[a];
            end
         end
         sum[a] = acc_x[a] + add_x[a] - cons[a];
         if (!en) begin
            acc_d[a] = '0;
         end else if (sum[a] > ACC_MAX) begin
            acc_d[a] = ACC_MAX[ACC_W-1:0];
         end else if (sum[a] < ACC_MIN) begin
            acc_d[a] = ACC_MIN[ACC_W-1:0];
         end else begin
            acc_d[a] = sum[a][ACC_W-1:0];
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pre_q <= '0;
         arm_q <= 1'b0;
         tog_q <= 1'b0;
         pkt_q <= 1'b0;
         for (int unsigned a = 0; a < 2; a++) begin
            add_q[a] <= '0;
            acc_q[a] <= '0;
            dir_q[a] <= 1'b0;
            stp_q[a] <= 1'b0;
         end
      end else begin
         pre_q <= pre_d;
         arm_q <= 1'b1;
         tog_q <= ps2_mouse[24];
         pkt_q <= pkt_d;
         for (int unsigned a = 0; a < 2; a++) begin
            add_q[a] <= add_d[a];
            acc_q[a] <= acc_d[a];
            dir_q[a] <= dir_d[a];
            stp_q[a] <= stp_d[a];
         end
      end
   end

   assign h_dir = dir_q[0] ^ flip;
   assign h_clk = stp_q[0];
   assign v_dir = dir_q[1] ^ flip;
   assign v_clk = stp_q[1];

endmodule
